// File: rtl/hamming16_pkg.sv
// Shared Hamming(21,16) definitions used by both the write side and the decoder.
package hamming16_pkg;

    localparam int DATA_W = 16;
    localparam int PAR_W  = 5;
    localparam int CW_W   = DATA_W + PAR_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } wr_state_e;

    // Parity bits {p4,p3,p2,p1,p0}; the decoder recomputes these to form its syndrome.
    function automatic logic [PAR_W-1:0] hamming16_parity(input logic [DATA_W-1:0] d);
        logic [PAR_W-1:0] p;
        p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[11] ^ d[13] ^ d[15];
        p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10] ^ d[12] ^ d[13];
        p[2] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10] ^ d[14] ^ d[15];
        p[3] = ^d[10:4];
        p[4] = ^d[15:11];
        return p;
    endfunction

endpackage

// File: rtl/hamming16_enc.sv
// Combinational data -> parity encoder.
module hamming16_enc
    import hamming16_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [PAR_W-1:0]  par_o
);

    assign par_o = hamming16_parity(data_i);

endmodule

// File: rtl/hamming16_mem_writer.sv
// Streams 16-bit words in, writes 21-bit Hamming codewords to consecutive
// memory addresses, with optional single-bit error injection.
module hamming16_mem_writer
    import hamming16_pkg::*;
#(
    parameter int AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [AW:0]       word_cnt,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              inj_en,
    input  logic [4:0]        inj_bit,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [AW-1:0]     mem_addr,
    output logic [CW_W-1:0]   mem_wdata,
    output logic              busy,
    output logic              done
);

    localparam logic [AW:0] REM_ONE = (AW+1)'(1);

    wr_state_e         state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;     // next address to assign
    logic [AW:0]       rem_q, rem_d;       // words still to accept
    logic              we_q, we_d;         // output register holds a pending write
    logic [AW-1:0]     maddr_q, maddr_d;
    logic [CW_W-1:0]   wdata_q, wdata_d;
    logic [PAR_W-1:0]  par;
    logic [CW_W-1:0]   inj_mask;
    logic              accept;

    hamming16_enc u_enc (
        .data_i (s_data),
        .par_o  (par)
    );

    // Out-of-range bit indices produce an empty mask, so injection is a no-op.
    always_comb begin
        inj_mask = '0;
        if (inj_en && (inj_bit <= 5'd20)) inj_mask = CW_W'(1) << inj_bit;
    end

    // Input may advance whenever the output register is empty or draining this cycle.
    assign s_ready = (state_q == ST_RUN) && (!we_q || mem_ready);
    assign accept  = s_valid && s_ready;

    // Next-state, counter and output-register update.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        we_d    = we_q;
        maddr_d = maddr_q;
        wdata_d = wdata_q;

        // A consumed write empties the register unless refilled below.
        if (we_q && mem_ready) we_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d  = base_addr;
                    rem_d   = word_cnt;
                    state_d = (word_cnt != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    we_d    = 1'b1;
                    maddr_d = addr_q;
                    wdata_d = {par, s_data} ^ inj_mask;
                    addr_d  = addr_q + AW'(1);
                    rem_d   = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!we_q || mem_ready) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any burst and drops pending writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            we_q    <= we_d;
            maddr_q <= maddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_hamming16_mem_writer.sv
// Scoreboard bench: driver pushes expected writes on each input handshake,
// monitor pops and compares whenever a write is taken by memory.
module tb_hamming16_mem_writer;

    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        rst, start, s_valid, s_ready, inj_en, mem_we, mem_ready, busy, done;
    logic [7:0]  base_addr, mem_addr;
    logic [8:0]  word_cnt;
    logic [15:0] s_data;
    logic [4:0]  inj_bit;
    logic [20:0] mem_wdata;

    hamming16_mem_writer #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_cnt(word_cnt),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .inj_en(inj_en),
        .inj_bit(inj_bit), .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [20:0] cw;
        logic [15:0] data;
        bit          inj;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] dq[$];     // directed data, consumed on accept
    int          injq[$];   // directed injection bit (-1 = none), consumed on accept
    int total = 0, bad = 0;
    int cyc = 0, wr_total = 0, done_cnt = 0, last_wr_cyc = -1, done_cyc = -1;

    // Parity-group membership masks, one per parity bit.
    logic [15:0] pmask [5] = '{16'hAD5B, 16'h366D, 16'hC78E, 16'h07F0, 16'hF800};

    function automatic logic [4:0] ref_par(input logic [15:0] d);
        logic [4:0] p;
        for (int i = 0; i < 5; i++) p[i] = ^(d & pmask[i]);
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: memory takes a write when mem_we && mem_ready at the next edge.
    initial begin
        exp_t       e;
        logic [4:0] syn;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && mem_we === 1'b1 && mem_ready) begin
                wr_total++;
                last_wr_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("unexpected_write", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("addr", mem_addr, e.addr);
                    chk("wdata", mem_wdata, e.cw);
                    if (!e.inj) begin
                        syn = ref_par(mem_wdata[15:0]) ^ mem_wdata[20:16];
                        chk("dec_err_flag", syn != 0, 0);
                        chk("dec_data", mem_wdata[15:0], e.data);
                    end
                end
            end
            if (!rst && done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic push_exp(input logic [7:0] a);
        exp_t e;
        e.addr = a;
        e.data = s_data;
        e.inj  = inj_en && (inj_bit <= 20);
        e.cw   = {ref_par(s_data), s_data} ^ (e.inj ? (21'd1 << inj_bit) : 21'd0);
        sb.push_back(e);
    endtask

    task automatic run_burst(input logic [7:0] base, input int cnt, input int vprob,
                             input int rprob, input bit stall);
        int acc = 0, budget, d0, start_cyc, ij;
        bit stalled = 0;
        logic [7:0]  ca;
        logic [20:0] cd;
        d0 = done_cnt;
        @(negedge clk);
        start = 1; base_addr = base; word_cnt = 9'(cnt);
        s_valid = 1'($urandom_range(0, 1)); mem_ready = 1;
        #1;
        chk("start_sready", s_ready, 0);
        start_cyc = cyc;
        @(negedge clk);
        start = 0; s_valid = 0;
        chk("busy_start", busy, (cnt != 0));
        budget = cnt * 30 + 50;
        while (done_cnt == d0 && budget > 0) begin
            if (stall && acc == 1 && !stalled) begin
                stalled = 1;
                for (int i = 0; i < 4; i++) begin
                    mem_ready = 0; s_valid = 1;
                    #1;
                    if (i == 0) begin ca = mem_addr; cd = mem_wdata; end
                    else begin
                        chk("stall_addr", mem_addr, ca);
                        chk("stall_wdata", mem_wdata, cd);
                    end
                    chk("stall_we", mem_we, 1);
                    chk("stall_sready", s_ready, 0);
                    @(negedge clk);
                end
            end
            s_valid = (acc < cnt) && ($urandom_range(0, 99) < vprob);
            s_data  = (dq.size() > 0) ? dq[0] : 16'($urandom);
            if (injq.size() > 0) ij = injq[0];
            else ij = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 31)) : -1;
            inj_en  = (ij >= 0);
            inj_bit = (ij >= 0) ? 5'(ij) : 5'($urandom);
            mem_ready = ($urandom_range(0, 99) < rprob);
            #1;
            if (s_valid && s_ready) begin
                push_exp(base + 8'(acc));
                acc++;
                if (dq.size() > 0) void'(dq.pop_front());
                if (injq.size() > 0) void'(injq.pop_front());
            end
            @(negedge clk);
            budget--;
        end
        s_valid = 0; inj_en = 0; mem_ready = 1;
        chk("done_seen", done_cnt - d0, 1);
        chk("accepted", acc, cnt);
        if (cnt == 0) chk("done_lat0", done_cyc, start_cyc + 1);
        else chk("done_lat", done_cyc, last_wr_cyc + 1);
        chk("sb_empty", sb.size(), 0);
        chk("done_one_cycle", done, 0);
        chk("busy_end", busy, 0);
    endtask

    initial begin
        int d0, w0, budget;
        rst = 1; start = 0; base_addr = 0; word_cnt = 0; s_valid = 0; s_data = 0;
        inj_en = 0; inj_bit = 0; mem_ready = 1;
        repeat (3) @(negedge clk);
        chk("rst_sready", s_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 0;

        // basic burst with directed data
        dq = '{16'h0000, 16'hFFFF, 16'h0001};
        injq = '{-1, -1, -1};
        run_burst(8'h10, 3, 100, 100, 0);

        // back-pressure hold
        run_burst(8'h30, 6, 100, 100, 1);

        // address wrap
        run_burst(8'hFE, 4, 100, 100, 0);

        // empty burst
        run_burst(8'h55, 0, 100, 100, 0);

        // injection: bit 3, clean, bit 16, out of range, clean
        dq = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        injq = '{3, -1, 16, 25, -1};
        run_burst(8'h00, 5, 100, 100, 0);

        // full-range burst with random handshakes
        run_burst(8'($urandom), 256, 70, 70, 0);

        // reset mid-burst after two writes
        d0 = done_cnt; w0 = wr_total;
        @(negedge clk);
        start = 1; base_addr = 8'h20; word_cnt = 9'd5; mem_ready = 1; s_valid = 0;
        @(negedge clk);
        start = 0;
        budget = 40;
        while (wr_total - w0 < 2 && budget > 0) begin
            s_valid = 1; s_data = 16'($urandom); inj_en = 0;
            #1;
            if (s_valid && s_ready) push_exp(8'h20 + 8'(wr_total - w0 + sb.size()));
            @(negedge clk);
            budget--;
        end
        chk("pre_rst_writes", wr_total - w0, 2);
        rst = 1; s_valid = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("abort_we", mem_we, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sready", s_ready, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_wdata", mem_wdata, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        chk("abort_no_write", mem_we, 0);
        run_burst(8'h40, 5, 100, 100, 0);

        // random bursts
        for (int b = 0; b < 6; b++)
            run_burst(8'($urandom), $urandom_range(1, 20), $urandom_range(30, 100),
                      $urandom_range(30, 100), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
